// File: rtl/lpf_conv3x3_engine_pkg.sv
// Shared types and constants for the 3x3 streaming filter engine.
package lpf_pkg;

  typedef enum logic [1:0] {
    MODE_BOX     = 2'd0,
    MODE_GAUSS   = 2'd1,
    MODE_PASS    = 2'd2,
    MODE_SHARPEN = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int unsigned BOX_MUL   = 7;
  localparam int unsigned BOX_SHR   = 6;
  localparam int unsigned GAUSS_SHR = 4;
  localparam int unsigned DRAIN_CYC = 3;

endpackage

// File: rtl/lpf_conv3x3_engine_if.sv
// Control handshake plus source-read and destination-write BRAM ports of the filter engine.
interface lpf_conv3x3_engine_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 16
) ();

  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport slave (
    input  start, mode, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, mode, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/lpf_conv3x3_engine_line_buffer.sv
// One-row delay line: q_o is the pixel pushed DEPTH pushes before the current one.
module lpf_line_buffer #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      sr_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/lpf_conv3x3_engine.sv
// Single-pass 3x3 filter: raster read, two line buffers, kernel select, raster write.
module lpf_conv3x3_engine #(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lpf_conv3x3_engine_if.slave  bus
);

  import lpf_pkg::*;

  localparam int unsigned N_PIX  = IMG_W * IMG_H;
  localparam int unsigned SCAN_W = $clog2(N_PIX + IMG_W + 1);
  localparam int unsigned SUM_W  = PIX_W + 6;
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam logic [SCAN_W-1:0] S_LAST = SCAN_W'(N_PIX + IMG_W);
  localparam logic [SCAN_W-1:0] S_NPIX = SCAN_W'(N_PIX);
  localparam logic [SCAN_W-1:0] S_WARM = SCAN_W'(IMG_W + 1);
  localparam logic [PIX_W-1:0]  PIX_MAX = '1;

  function automatic logic [SUM_W-1:0] ext(input logic [PIX_W-1:0] p);
    return SUM_W'(p);
  endfunction

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [SCAN_W-1:0]   s_q, s_d, iss_s_q, iss_s_d;
  logic [1:0]          drain_q, drain_d;
  logic                iss_vld_q, iss_vld_d, rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_BOX;
      s_q       <= '0;
      iss_s_q   <= '0;
      drain_q   <= '0;
      iss_vld_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      s_q       <= s_d;
      iss_s_q   <= iss_s_d;
      drain_q   <= drain_d;
      iss_vld_q <= iss_vld_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Slot 0 is issued on the accept edge itself, so RUN starts at slot 1.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    s_d       = s_q;
    iss_s_d   = iss_s_q;
    drain_d   = drain_q;
    iss_vld_d = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          mode_d    = mode_e'(bus.mode);
          iss_vld_d = 1'b1;
          iss_s_d   = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          s_d       = SCAN_W'(1);
        end
      end
      ST_RUN: begin
        iss_vld_d = 1'b1;
        iss_s_d   = s_q;
        rd_en_d   = (s_q < S_NPIX);
        if (s_q < S_NPIX) rd_addr_d = ADDR_W'(s_q);
        s_d = s_q + SCAN_W'(1);
        if (s_q == S_LAST) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(DRAIN_CYC - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  logic              vld1_q, rd1_q;
  logic [SCAN_W-1:0] s1_q;
  logic [PIX_W-1:0]  pix_in, lb1_q, lb2_q;
  logic [PIX_W-1:0]  t1_q, m1_q, b1_q, t2_q, m2_q, b2_q;
  logic [ADDR_W-1:0] k_q;
  logic [COL_W-1:0]  kc_q;
  logic [ROW_W-1:0]  kr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;
  logic              wr_fire, accept;

  assign pix_in  = rd1_q ? bus.rd_data : '0;
  assign wr_fire = vld1_q && (s1_q >= S_WARM);
  assign accept  = (state_q == ST_IDLE) && bus.start;

  lpf_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_mid (
    .clk(clk), .en_i(vld1_q), .d_i(pix_in), .q_o(lb1_q)
  );

  lpf_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_top (
    .clk(clk), .en_i(vld1_q), .d_i(lb1_q), .q_o(lb2_q)
  );

  // Window columns: {lb2_q,lb1_q,pix_in} newest, *1_q centre column, *2_q oldest.
  logic [SUM_W-1:0] sum9, gsum, box_p, pos, neg, diff;
  logic [PIX_W-1:0] kern, res;
  logic             interior;

  always_comb begin
    sum9  = ext(t2_q) + ext(t1_q) + ext(lb2_q) + ext(m2_q) + ext(m1_q)
          + ext(lb1_q) + ext(b2_q) + ext(b1_q) + ext(pix_in);
    gsum  = ext(t2_q) + ext(lb2_q) + ext(b2_q) + ext(pix_in)
          + ((ext(t1_q) + ext(m2_q) + ext(lb1_q) + ext(b1_q)) << 1)
          + (ext(m1_q) << 2);
    box_p = sum9 * SUM_W'(BOX_MUL);
    pos   = ext(m1_q) * SUM_W'(5);
    neg   = ext(t1_q) + ext(b1_q) + ext(m2_q) + ext(lb1_q);
    diff  = '0;
    kern  = m1_q;
    unique case (mode_q)
      MODE_BOX:   kern = PIX_W'(box_p >> BOX_SHR);
      MODE_GAUSS: kern = PIX_W'(gsum >> GAUSS_SHR);
      MODE_PASS:  kern = m1_q;
      MODE_SHARPEN: begin
        if (neg >= pos) begin
          kern = '0;
        end else begin
          diff = pos - neg;
          kern = (diff > ext(PIX_MAX)) ? PIX_MAX : PIX_W'(diff);
        end
      end
      default: kern = m1_q;
    endcase
    interior = (kc_q != '0) && (kc_q != COL_W'(IMG_W - 1))
            && (kr_q != '0) && (kr_q != ROW_W'(IMG_H - 1));
    res = interior ? kern : m1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q    <= 1'b0;
      rd1_q     <= 1'b0;
      s1_q      <= '0;
      t1_q      <= '0;
      m1_q      <= '0;
      b1_q      <= '0;
      t2_q      <= '0;
      m2_q      <= '0;
      b2_q      <= '0;
      k_q       <= '0;
      kc_q      <= '0;
      kr_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      vld1_q  <= iss_vld_q;
      rd1_q   <= rd_en_q;
      s1_q    <= iss_s_q;
      wr_en_q <= wr_fire;
      if (vld1_q) begin
        t2_q <= t1_q;
        m2_q <= m1_q;
        b2_q <= b1_q;
        t1_q <= lb2_q;
        m1_q <= lb1_q;
        b1_q <= pix_in;
      end
      if (accept) begin
        k_q  <= '0;
        kc_q <= '0;
        kr_q <= '0;
      end else if (wr_fire) begin
        wr_addr_q <= k_q;
        wr_data_q <= res;
        k_q       <= k_q + ADDR_W'(1);
        if (kc_q == COL_W'(IMG_W - 1)) begin
          kc_q <= '0;
          kr_q <= (kr_q == ROW_W'(IMG_H - 1)) ? '0 : kr_q + ROW_W'(1);
        end else begin
          kc_q <= kc_q + COL_W'(1);
        end
      end
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_lpf_conv3x3_engine.sv
// Directed scoreboard bench for lpf_conv3x3_engine on a 4x4 frame with a 1-clk BRAM model.
module tb_lpf_conv3x3_engine;

  import lpf_pkg::*;

  localparam int unsigned W = 4, H = 4, N = 16, PIXW = 8, AW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lpf_conv3x3_engine_if #(.PIX_W(PIXW), .ADDR_W(AW)) bus ();

  lpf_conv3x3_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(PIXW), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int unsigned addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [N];
  int n_assert = 0, n_fail = 0;
  int cyc = 0, base = 0;
  int n_wr = 0, n_rd = 0, rd_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ref_px(input int k, input int md);
    int r, c, v;
    int p [3][3];
    r = k / W;
    c = k % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return mem[k];
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        p[dr][dc] = int'(mem[(r + dr - 1) * W + c + dc - 1]);
    case (md)
      0: begin
        v = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++) v += p[dr][dc];
        v = (v * 7) >> 6;
      end
      1: v = (p[0][0] + 2*p[0][1] + p[0][2] + 2*p[1][0] + 4*p[1][1] + 2*p[1][2]
             + p[2][0] + 2*p[2][1] + p[2][2]) >> 4;
      2: v = p[1][1];
      default: begin
        v = 5*p[1][1] - p[0][1] - p[2][1] - p[1][0] - p[1][2];
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end
    endcase
    return 8'(v);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.rd_en) begin
      chk("rd_addr", 32'(bus.rd_addr), 32'(rd_exp));
      rd_exp++;
      n_rd++;
    end
    if (bus.wr_en) begin
      n_wr++;
      chk("wr_expected", 32'(sb.size() > 0), 32'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", 32'(bus.wr_data), 32'(e.data));
        chk("wr_cycle", 32'(cyc - base), 32'(e.cyc));
      end
    end
  end

  task automatic push_frame(input int md);
    for (int k = 0; k < N; k++) sb.push_back('{k, ref_px(k, md), k + W + 4});
  endtask

  task automatic start_frame(input int md);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'(md);
    rd_exp = 0;
    n_rd   = 0;
    n_wr   = 0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mode  = 2'(md ^ 3);
    base = cyc - 1;
  endtask

  task automatic run_frame(input int md, input bit repulse);
    int done_c, c;
    push_frame(md);
    start_frame(md);
    done_c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      c = cyc - base;
      if (repulse && c == 5) begin
        bus.start = 1'b1;
        bus.mode  = 2'(md ^ 1);
      end
      if (repulse && c == 6) bus.start = 1'b0;
      if (bus.done) begin
        done_c = c;
        break;
      end
    end
    chk("done_cycle", 32'(done_c), 32'(N + W + 4));
    chk("busy_at_done", 32'(bus.busy), 32'(1));
    chk("wr_count", 32'(n_wr), 32'(N));
    chk("rd_count", 32'(n_rd), 32'(N));
    chk("sb_drained", 32'(sb.size()), 32'(0));
    sb.delete();
  endtask

  task automatic check_idle();
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'(0));
    chk("idle_done", 32'(bus.done), 32'(0));
  endtask

  initial begin
    int dones;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_rd_en", 32'(bus.rd_en), 32'(0));
    chk("rst_wr_en", 32'(bus.wr_en), 32'(0));
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'(0));
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
    chk("rst_wr_data", 32'(bus.wr_data), 32'(0));
    rst = 1'b0;

    for (int k = 0; k < N; k++) mem[k] = 8'd100;
    chk("box_model_interior", 32'(ref_px(5, 0)), 32'(98));
    run_frame(MODE_BOX, 1'b0);
    check_idle();
    run_frame(MODE_GAUSS, 1'b0);
    check_idle();

    for (int k = 0; k < N; k++) mem[k] = 8'd0;
    mem[5] = 8'd200;
    run_frame(MODE_SHARPEN, 1'b0);
    check_idle();

    for (int k = 0; k < N; k++) mem[k] = 8'(k * 10);
    run_frame(MODE_PASS, 1'b1);
    run_frame(MODE_PASS, 1'b0);
    check_idle();

    for (int md = 0; md < 4; md++) begin
      for (int k = 0; k < N; k++) mem[k] = 8'($urandom_range(0, 255));
      run_frame(md, 1'b0);
    end
    check_idle();

    push_frame(MODE_BOX);
    start_frame(MODE_BOX);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc - base == 10) break;
    end
    rst = 1'b1;
    @(posedge clk);
    sb.delete();
    n_wr = 0;
    n_rd = 0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_rd_en", 32'(bus.rd_en), 32'(0));
    chk("abort_wr_en", 32'(bus.wr_en), 32'(0));
    chk("abort_done", 32'(bus.done), 32'(0));
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'(0));
    chk("abort_no_wr", 32'(n_wr), 32'(0));
    chk("abort_no_rd", 32'(n_rd), 32'(0));

    for (int k = 0; k < N; k++) mem[k] = 8'($urandom_range(0, 255));
    run_frame(MODE_GAUSS, 1'b0);
    check_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
